text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console_pkg.sv | 20 ++
 rtl/text_console_if.sv | 10 +
 rtl/text_buffer.sv | 28 ++
 rtl/text_console.sv | 220 ++++++++++++++++++++++
 tb/tb_text_console.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: controller states and the
// ASCII control codes it reacts to.
package text_console_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        SCROLL = 2'd2
    } state_e;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Character input handshake: the source offers a byte, the console
// accepts it on a cycle where both valid and ready are high.
interface text_console_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;

    modport master (output in_valid, output in_char, input in_ready);
    modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/text_buffer.sv
// Character cell store: one synchronous write port, two asynchronous
// read ports (display refresh and scroll copy).
module text_buffer #(
    parameter int CELLS = 2100,
    parameter int IDX_W = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] disp_addr,
    output logic [7:0]       disp_data,
    input  logic [IDX_W-1:0] scroll_addr,
    output logic [7:0]       scroll_data
);

    logic [7:0] mem [CELLS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign disp_data   = mem[disp_addr];
    assign scroll_data = mem[scroll_addr];

endmodule

// File: rtl/text_console.sv
// Character-cell text console: accepts ASCII over a valid/ready port,
// maintains a scrolling buffer and renders it through a 2-stage pixel path.
//
//   state  | meaning
//   CLEAR  | writing SPACE to every cell, cursor forced to (0,0) at the end
//   IDLE   | accepting characters, cursor blink shown
//   SCROLL | shifting rows up by one, then blanking the last row
module text_console
    import text_console_pkg::*;
#(
    parameter int          COLS         = 70,
    parameter int          ROWS         = 30,
    parameter int          CHAR_W       = 9,
    parameter int          CHAR_H       = 16,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int          BLINK_CYCLES = 25000000
) (
    input  logic                          clk,
    input  logic                          resetn,
    text_console_if.slave                 con,
    input  logic [9:0]                    h_addr,
    input  logic [9:0]                    v_addr,
    output logic [8+$clog2(CHAR_H)-1:0]   font_addr,
    input  logic [CHAR_W-1:0]             font_row,
    output logic [23:0]                   vga_data,
    output logic [$clog2(COLS)-1:0]       cursor_col,
    output logic [$clog2(ROWS)-1:0]       cursor_row
);

    localparam int CELLS     = COLS * ROWS;
    localparam int IDX_W     = $clog2(CELLS);
    localparam int COL_W     = $clog2(COLS);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int GROW_W    = $clog2(CHAR_H);
    localparam int GCOL_W    = $clog2(CHAR_W);
    localparam int BLINK_W   = $clog2(BLINK_CYCLES + 1);
    localparam int SHIFT_END = CELLS - COLS;

    localparam logic [1:0] S_CLEAR  = CLEAR;
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SCROLL = SCROLL;

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [COL_W-1:0]   cur_col;
    logic [ROW_W-1:0]   cur_row;
    logic [IDX_W-1:0]   cur_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic               accept;
    logic               printable;
    logic               newline;
    logic               last_idx;

    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [7:0]         wdata;
    logic [IDX_W-1:0]   scroll_addr;
    logic [7:0]         scroll_data;
    logic [IDX_W-1:0]   disp_addr;
    logic [7:0]         disp_data;
    logic               in_area;

    logic [7:0]         s1_char;
    logic [GROW_W-1:0]  s1_grow;
    logic [GCOL_W-1:0]  s1_gcol;
    logic               s1_in_area;
    logic               s1_invert;
    logic [23:0]        pix;

    assign con.in_ready = (state == S_IDLE);
    assign accept       = con.in_valid & con.in_ready;
    assign printable    = is_printable(con.in_char);
    assign newline      = accept && ((printable && int'(cur_col) == COLS - 1) || con.in_char == LF);
    assign last_idx     = (int'(idx) == CELLS - 1);
    assign cur_idx      = IDX_W'(int'(cur_row) * COLS + int'(cur_col));
    assign cursor_col   = cur_col;
    assign cursor_row   = cur_row;

    // Past the shift region the scroll port is unused; keep its address in range.
    assign scroll_addr = (int'(idx) < SHIFT_END) ? IDX_W'(int'(idx) + COLS) : idx;

    always_comb begin
        we    = 1'b0;
        waddr = idx;
        wdata = SPACE;
        case (state)
            S_CLEAR: we = 1'b1;
            S_SCROLL: begin
                we = 1'b1;
                if (int'(idx) < SHIFT_END) begin
                    wdata = scroll_data;
                end
            end
            S_IDLE: begin
                if (accept && printable) begin
                    we    = 1'b1;
                    waddr = cur_idx;
                    wdata = con.in_char;
                end else if (accept && con.in_char == BS && cur_col != '0) begin
                    we    = 1'b1;
                    waddr = cur_idx - IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_CLEAR;
            idx     <= '0;
            cur_col <= '0;
            cur_row <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (last_idx) begin
                        idx     <= '0;
                        cur_col <= '0;
                        cur_row <= '0;
                        state   <= S_IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_SCROLL: begin
                    if (last_idx) begin
                        idx   <= '0;
                        state <= S_IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_IDLE: begin
                    if (newline) begin
                        cur_col <= '0;
                        if (int'(cur_row) == ROWS - 1) begin
                            idx   <= '0;
                            state <= S_SCROLL;
                        end else begin
                            cur_row <= cur_row + ROW_W'(1);
                        end
                    end else if (accept && printable) begin
                        cur_col <= cur_col + COL_W'(1);
                    end else if (accept && con.in_char == BS && cur_col != '0) begin
                        cur_col <= cur_col - COL_W'(1);
                    end else if (accept && con.in_char == FF) begin
                        idx   <= '0;
                        state <= S_CLEAR;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (int'(blink_cnt) == BLINK_CYCLES - 1) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    text_buffer #(.CELLS(CELLS), .IDX_W(IDX_W)) u_buf (
        .clk         (clk),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .scroll_addr (scroll_addr),
        .scroll_data (scroll_data)
    );

    assign in_area   = (int'(h_addr) < COLS * CHAR_W) && (int'(v_addr) < ROWS * CHAR_H);
    assign disp_addr = in_area ?
        IDX_W'((int'(v_addr) / CHAR_H) * COLS + int'(h_addr) / CHAR_W) : '0;

    // The cursor inversion decision is folded into stage 1 so stage 2 is a pure mux.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_char    <= '0;
            s1_grow    <= '0;
            s1_gcol    <= '0;
            s1_in_area <= 1'b0;
            s1_invert  <= 1'b0;
        end else begin
            s1_char    <= disp_data;
            s1_grow    <= GROW_W'(int'(v_addr) % CHAR_H);
            s1_gcol    <= GCOL_W'(int'(h_addr) % CHAR_W);
            s1_in_area <= in_area;
            s1_invert  <= in_area && (disp_addr == cur_idx) && (state == S_IDLE) && blink_phase;
        end
    end

    assign font_addr = {s1_char, s1_grow};
    assign pix       = font_row[s1_gcol] ? FG_COLOR : BG_COLOR;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vga_data <= '0;
        end else if (!s1_in_area) begin
            vga_data <= BG_COLOR;
        end else begin
            vga_data <= s1_invert ? ~pix : pix;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Randomized scoreboard bench for text_console: a character-grid model
// predicts cursor, busy periods and rendered pixels.
module tb_text_console;

    localparam int COLS   = 4;
    localparam int ROWS   = 3;
    localparam int CHAR_W = 9;
    localparam int CHAR_H = 16;
    localparam int BLINK  = 8;
    localparam int CELLS  = COLS * ROWS;
    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  h_addr = '0;
    logic [9:0]  v_addr = '0;
    logic [11:0] font_addr;
    logic [8:0]  font_row;
    logic [23:0] vga_data;
    logic [1:0]  cursor_col;
    logic [1:0]  cursor_row;

    text_console_if con();

    text_console #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
        .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .con        (con),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .font_addr  (font_addr),
        .font_row   (font_row),
        .vga_data   (vga_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] font_fn(input logic [11:0] a);
        int v;
        v = int'(a) * 37 + (int'(a) >> 3) * 11 + 5;
        return 9'(v ^ (v >> 4));
    endfunction

    assign font_row = font_fn(font_addr);

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int k_en = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) k_en <= 0;
        else         k_en <= k_en + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [23:0] val;
    } exp_t;

    exp_t fa_q[$];
    exp_t vga_q[$];

    always @(negedge clk) begin
        exp_t e;
        while (fa_q.size() > 0 && fa_q[0].due <= cyc) begin
            e = fa_q.pop_front();
            if (e.due == cyc) check("font_addr", int'(font_addr), int'(e.val));
            else              check("font_addr_missed", cyc, e.due);
        end
        while (vga_q.size() > 0 && vga_q[0].due <= cyc) begin
            e = vga_q.pop_front();
            if (e.due == cyc) check("vga_data", int'(vga_data), int'(e.val));
            else              check("vga_data_missed", cyc, e.due);
        end
    end

    logic [7:0] mbuf [CELLS];
    int mrow = 0;
    int mcol = 0;

    task automatic model_clear();
        foreach (mbuf[i]) mbuf[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < (ROWS - 1) * COLS; i++) mbuf[i] = mbuf[i + COLS];
        for (int i = (ROWS - 1) * COLS; i < CELLS; i++) mbuf[i] = 8'h20;
    endtask

    task automatic model_newline(inout int busy);
        mcol = 0;
        if (mrow < ROWS - 1) mrow++;
        else begin
            model_scroll();
            busy = CELLS;
        end
    endtask

    task automatic model_apply(input logic [7:0] ch, output int busy);
        busy = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            mbuf[mrow * COLS + mcol] = ch;
            if (mcol < COLS - 1) mcol++;
            else model_newline(busy);
        end else if (ch == 8'h0A) begin
            model_newline(busy);
        end else if (ch == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                mbuf[mrow * COLS + mcol] = 8'h20;
            end
        end else if (ch == 8'h0C) begin
            model_clear();
            busy = CELLS;
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!con.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_cursor_row"}, int'(cursor_row), mrow);
        check({tag, "_cursor_col"}, int'(cursor_col), mcol);
    endtask

    task automatic send(input logic [7:0] ch);
        int busy;
        int n;
        con.in_valid = 1'b1;
        con.in_char  = ch;
        n = 0;
        while (!con.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!con.in_ready) begin
            check("accept_timeout", 0, 1);
            con.in_valid = 1'b0;
            return;
        end
        model_apply(ch, busy);
        @(negedge clk);
        con.in_valid = 1'b0;
        count_busy(n);
        check("busy_cycles", n, busy);
        check_cursor("send");
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset(input int hold);
        int n;
        resetn = 1'b0;
        con.in_valid = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            check("ready_in_reset", int'(con.in_ready), 0);
        end
        check("reset_cursor_row", int'(cursor_row), 0);
        check("reset_cursor_col", int'(cursor_col), 0);
        check("reset_vga", int'(vga_data), 0);
        resetn = 1'b1;
        count_busy(n);
        check("clear_after_reset", n, CELLS);
        model_clear();
        check_cursor("reset");
    endtask

    task automatic probe(input int h, input int v);
        exp_t e;
        logic [11:0] fa;
        logic [8:0]  bits;
        logic [23:0] col;
        int r, c, gcol;
        h_addr = 10'(h);
        v_addr = 10'(v);
        if (h < COLS * CHAR_W && v < ROWS * CHAR_H) begin
            r    = v / CHAR_H;
            c    = h / CHAR_W;
            gcol = h % CHAR_W;
            fa   = {mbuf[r * COLS + c], 4'(v % CHAR_H)};
            bits = font_fn(fa);
            col  = bits[gcol] ? FG : BG;
            if (r == mrow && c == mcol && ((k_en / BLINK) % 2) == 1) col = ~col;
            e.due = cyc + 1; e.val = 24'(fa);
            fa_q.push_back(e);
        end else begin
            col = BG;
        end
        e.due = cyc + 2; e.val = col;
        vga_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic scan_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                probe(c * CHAR_W + int'($urandom_range(0, CHAR_W - 1)),
                      r * CHAR_H + int'($urandom_range(0, CHAR_H - 1)));
        probe(COLS * CHAR_W + int'($urandom_range(0, 900)), int'($urandom_range(0, 1023)));
        probe(int'($urandom_range(0, 1023)), ROWS * CHAR_H + int'($urandom_range(0, 900)));
        drain();
    endtask

    task automatic probe_cursor();
        for (int i = 0; i < 2 * BLINK + 4; i++)
            probe(mcol * CHAR_W + (i % CHAR_W), mrow * CHAR_H + (i % CHAR_H));
        drain();
    endtask

    function automatic logic [7:0] rand_char();
        int sel;
        logic [7:0] ign [6];
        ign[0] = 8'h00; ign[1] = 8'h07; ign[2] = 8'h7F;
        ign[3] = 8'h80; ign[4] = 8'hFF; ign[5] = 8'h1B;
        sel = int'($urandom_range(0, 99));
        if (sel < 68) return 8'($urandom_range(8'h20, 8'h7E));
        if (sel < 80) return 8'h0A;
        if (sel < 90) return 8'h08;
        if (sel < 97) return ign[$urandom_range(0, 5)];
        return 8'h0C;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        con.in_valid = 1'b0;
        con.in_char  = 8'h00;
        model_clear();
        @(negedge clk);
        do_reset(3);
        scan_all();

        send_str("ABCDE");
        scan_all();
        probe_cursor();

        send(8'h0C);
        send_str("ABCDEFGHIJKL");
        scan_all();

        send(8'h0C);
        send_str("AB");
        send(8'h08); send(8'h08); send(8'h08);
        scan_all();
        send(8'h0C);

        send("A");
        probe(0, 0);
        probe(36, 0);
        probe(0, 48);
        probe(35, 47);
        drain();

        send(8'h0A); send(8'h0A); send(8'h0A);
        send(8'h07); send(8'hFF);
        scan_all();

        for (int i = 0; i < 60; i++) begin
            send(rand_char());
            if (i % 15 == 14) scan_all();
        end
        probe_cursor();

        send(8'h0C);
        send_str("ABCDEFGHIJK");
        con.in_valid = 1'b1;
        con.in_char  = "L";
        n = 0;
        while (!con.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        con.in_valid = 1'b0;
        repeat (4) begin
            check("ready_mid_scroll", int'(con.in_ready), 0);
            @(negedge clk);
        end
        do_reset(2);
        scan_all();
        send_str("XY");
        scan_all();

        drain();
        check("queue_drain", fa_q.size() + vga_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
